mem_arbiter: RTL and testbench

//   Shares the single-ported RAM between the instruction and data ports of

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction and data
// ports of CPUS caches. It grants one request at a time, scanning the CPUs
// round-robin from rr_ptr. Within a CPU the priority is data write, then data
// read, then instruction read. The grant is held until the RAM reports ACCESS.
// The winner's wait line then drops for exactly that one cycle.
module mem_arbiter #(
    parameter int CPUS = 2,
    parameter int WORD = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*WORD-1:0] iaddr,
    input  logic [CPUS*WORD-1:0] daddr,
    input  logic [CPUS*WORD-1:0] dstore,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*WORD-1:0] iload,
    output logic [CPUS*WORD-1:0] dload,
    output logic [WORD-1:0]      ramaddr,
    output logic [WORD-1:0]      ramstore,
    output logic                 ramREN,
    output logic                 ramWEN,
    input  logic [1:0]           ramstate,
    input  logic [WORD-1:0]      ramload
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic [1:0] {KIND_I = 2'd0, KIND_R = 2'd1, KIND_W = 2'd2} kind_t;

    state_t          state_r,     state_s;
    logic [CW-1:0]   rr_ptr_r,    rr_ptr_s;
    logic [CW-1:0]   gnt_cpu_r,   gnt_cpu_s;
    kind_t           gnt_kind_r,  gnt_kind_s;
    logic [WORD-1:0] gnt_addr_r,  gnt_addr_s;
    logic [WORD-1:0] gnt_store_r, gnt_store_s;

    logic            found_s;
    logic            req_live_s;
    int              scan_idx_s;

    // Read data is fanned out to every port. It is only meaningful in the ACCESS cycle.
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // State, round-robin pointer and grant registers, with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            gnt_cpu_r   <= '0;
            gnt_kind_r  <= KIND_I;
            gnt_addr_r  <= '0;
            gnt_store_r <= '0;
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            gnt_cpu_r   <= gnt_cpu_s;
            gnt_kind_r  <= gnt_kind_s;
            gnt_addr_r  <= gnt_addr_s;
            gnt_store_r <= gnt_store_s;
        end
    end

    // Next-state logic: the round-robin scan in IDLE, and the RAM drive and completion/abort in BUSY.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        gnt_cpu_s   = gnt_cpu_r;
        gnt_kind_s  = gnt_kind_r;
        gnt_addr_s  = gnt_addr_r;
        gnt_store_s = gnt_store_r;
        found_s     = 1'b0;
        req_live_s  = 1'b0;
        scan_idx_s  = 0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = {WORD{1'b0}};
        ramstore    = {WORD{1'b0}};
        iwait       = {CPUS{1'b1}};
        dwait       = {CPUS{1'b1}};

        case (state_r)
            IDLE: begin
                for (int i = 0; i < CPUS; i++) begin
                    scan_idx_s = int'(rr_ptr_r) + i;
                    if (scan_idx_s >= CPUS) begin
                        scan_idx_s = scan_idx_s - CPUS;
                    end else begin
                        scan_idx_s = scan_idx_s;
                    end
                    if (!found_s && (iREN[scan_idx_s] || dREN[scan_idx_s] || dWEN[scan_idx_s])) begin
                        found_s   = 1'b1;
                        gnt_cpu_s = CW'(scan_idx_s);
                        state_s   = BUSY;
                        // A write wins even when a read is raised alongside it.
                        if (dWEN[scan_idx_s]) begin
                            gnt_kind_s  = KIND_W;
                            gnt_addr_s  = daddr[scan_idx_s*WORD +: WORD];
                            gnt_store_s = dstore[scan_idx_s*WORD +: WORD];
                        end else if (dREN[scan_idx_s]) begin
                            gnt_kind_s  = KIND_R;
                            gnt_addr_s  = daddr[scan_idx_s*WORD +: WORD];
                            gnt_store_s = {WORD{1'b0}};
                        end else begin
                            gnt_kind_s  = KIND_I;
                            gnt_addr_s  = iaddr[scan_idx_s*WORD +: WORD];
                            gnt_store_s = {WORD{1'b0}};
                        end
                    end else begin
                        found_s = found_s;
                    end
                end
            end
            BUSY: begin
                ramaddr = gnt_addr_r;
                case (gnt_kind_r)
                    KIND_W: begin
                        ramWEN     = 1'b1;
                        ramstore   = gnt_store_r;
                        req_live_s = dWEN[gnt_cpu_r];
                    end
                    KIND_R: begin
                        ramREN     = 1'b1;
                        req_live_s = dREN[gnt_cpu_r];
                    end
                    default: begin
                        ramREN     = 1'b1;
                        req_live_s = iREN[gnt_cpu_r];
                    end
                endcase
                if (!req_live_s) begin
                    // The requester gave up, so drop the grant without a pulse and keep the pointer.
                    state_s = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    if (gnt_kind_r == KIND_I) begin
                        iwait[gnt_cpu_r] = 1'b0;
                    end else begin
                        dwait[gnt_cpu_r] = 1'b0;
                    end
                    state_s = IDLE;
                    if (gnt_cpu_r == CW'(CPUS - 1)) begin
                        rr_ptr_s = {CW{1'b0}};
                    end else begin
                        rr_ptr_s = gnt_cpu_r + CW'(1);
                    end
                end else begin
                    // FREE, BUSY or ERROR: keep the grant and retry.
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Directed vector table plus hand sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int CPUS = 2;
    localparam int WORD = 32;
    localparam int VW   = 2 + 2*WORD + 2*CPUS + 2*CPUS*WORD;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [CPUS-1:0]      iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS*WORD-1:0] iaddr, daddr, dstore, iload, dload;
    logic [WORD-1:0]      ramaddr, ramstore, ramload;
    logic                 ramREN, ramWEN;
    logic [1:0]           ramstate;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.CPUS(CPUS), .WORD(WORD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramstate(ramstate), .ramload(ramload)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        nrst;
        logic [1:0]  ir, dr, dw, rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dwx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic n, input logic [1:0] ir, input logic [1:0] dr,
                                input logic [1:0] dw, input logic [1:0] rs, input logic ren,
                                input logic wen, input logic [31:0] a, input logic [31:0] s,
                                input logic [1:0] iw, input logic [1:0] dwx);
        vec_t v;
        v.nrst = n; v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs;
        v.ren = ren; v.wen = wen; v.addr = a; v.store = s; v.iw = iw; v.dwx = dwx;
        return v;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] exp);
        logic [VW-1:0] act;
        act = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, compare 1 ns later, and let the following posedge commit.
    task automatic apply_row(input vec_t v, input string name);
        @(negedge CLK);
        nRST = v.nrst; iREN = v.ir; dREN = v.dr; dWEN = v.dw; ramstate = v.rs;
        #1;
        check(name, {v.ren, v.wen, v.addr, v.store, v.iw, v.dwx, {CPUS{ramload}}, {CPUS{ramload}}});
    endtask

    // Transaction-level reference model state.
    logic        m_act;
    int          m_cpu, m_kind, m_rr;   // kind: 0 instr read, 1 data read, 2 data write
    logic [31:0] m_addr, m_store;

    initial begin
        logic        e_ren, e_wen, live, found;
        logic [31:0] e_addr, e_store;
        logic [1:0]  e_iw, e_dw;
        int          c, r;

        nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = 2'd0;
        iaddr  = {32'h0000_0140, 32'h0000_0040};
        daddr  = {32'h0000_0180, 32'h0000_0080};
        dstore = {32'h0000_BEEF, 32'h0000_DEAD};
        ramload = 32'h1234_5678;
        repeat (2) @(posedge CLK);

        // Reset with all requests high.
        repeat (3) tbl.push_back(mk(1'b0, 2'b11, 2'b11, 2'b11, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        // Single instruction read, ACCESS two cycles after the enable.
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 2'b11));
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        // Write beats instruction read on the same CPU.
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b01, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b01, 2'd2, 1'b0, 1'b1, 32'h80, 32'hDEAD, 2'b11, 2'b10));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b01, 2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 2'b11));
        tbl.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        // Round-robin with both CPUs holding dREN (pointer is 1 here).
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(1'b1, 2'b00, 2'b11, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
            if (k == 1)
                tbl.push_back(mk(1'b1, 2'b00, 2'b11, 2'b00, 2'd2, 1'b1, 1'b0, 32'h80, 32'h0, 2'b11, 2'b10));
            else
                tbl.push_back(mk(1'b1, 2'b00, 2'b11, 2'b00, 2'd2, 1'b1, 1'b0, 32'h180, 32'h0, 2'b11, 2'b01));
        end
        // One CPU0 read, which moves the pointer to 1.
        tbl.push_back(mk(1'b1, 2'b00, 2'b01, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1'b1, 2'b00, 2'b01, 2'b00, 2'd2, 1'b1, 1'b0, 32'h80, 32'h0, 2'b11, 2'b10));

        for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], $sformatf("tbl%0d", i));

        // ERROR retried five times, then abort: no pulse and the pointer stays 1.
        apply_row(mk(1'b1, 2'b00, 2'b10, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11), "err_grant");
        for (int i = 0; i < 5; i++)
            apply_row(mk(1'b1, 2'b00, 2'b10, 2'b00, 2'd3, 1'b1, 1'b0, 32'h180, 32'h0, 2'b11, 2'b11), $sformatf("err_hold%0d", i));
        apply_row(mk(1'b1, 2'b00, 2'b00, 2'b00, 2'd3, 1'b1, 1'b0, 32'h180, 32'h0, 2'b11, 2'b11), "abort");
        apply_row(mk(1'b1, 2'b00, 2'b11, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11), "abort_idle");
        apply_row(mk(1'b1, 2'b00, 2'b11, 2'b00, 2'd2, 1'b1, 1'b0, 32'h180, 32'h0, 2'b11, 2'b01), "rr_kept");

        // Reset in the middle of a BUSY transaction.
        apply_row(mk(1'b1, 2'b10, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11), "mid_grant");
        apply_row(mk(1'b1, 2'b10, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, 32'h140, 32'h0, 2'b11, 2'b11), "mid_busy");
        apply_row(mk(1'b0, 2'b10, 2'b00, 2'b00, 2'd0, 1'b1, 1'b0, 32'h140, 32'h0, 2'b11, 2'b11), "mid_rst");
        apply_row(mk(1'b1, 2'b10, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11), "post_rst");
        apply_row(mk(1'b1, 2'b10, 2'b00, 2'b00, 2'd2, 1'b1, 1'b0, 32'h140, 32'h0, 2'b01, 2'b11), "post_serve");
        apply_row(mk(1'b0, 2'b00, 2'b00, 2'b00, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11), "pre_rand_rst");

        // Randomized traffic against the reference model.
        m_act = 1'b0; m_rr = 0; m_cpu = 0; m_kind = 0; m_addr = '0; m_store = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            nRST = 1'b1;
            for (int b = 0; b < CPUS; b++) begin
                if ($urandom_range(0, 7) == 0) iREN[b] = ~iREN[b];
                if ($urandom_range(0, 7) == 0) dREN[b] = ~dREN[b];
                if ($urandom_range(0, 9) == 0) dWEN[b] = ~dWEN[b];
            end
            iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom}; ramload = $urandom;
            r = $urandom_range(0, 5);
            ramstate = (r >= 3) ? 2'd2 : 2'(r);
            #1;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iw = '1; e_dw = '1;
            if (m_act) begin
                e_ren = (m_kind != 2); e_wen = (m_kind == 2); e_addr = m_addr;
                e_store = (m_kind == 2) ? m_store : 32'h0;
                live = (m_kind == 2) ? dWEN[m_cpu] : (m_kind == 1) ? dREN[m_cpu] : iREN[m_cpu];
                if (live && ramstate == 2'd2) begin
                    if (m_kind == 0) e_iw[m_cpu] = 1'b0; else e_dw[m_cpu] = 1'b0;
                end
            end
            check($sformatf("rand%0d", cyc), {e_ren, e_wen, e_addr, e_store, e_iw, e_dw, {CPUS{ramload}}, {CPUS{ramload}}});
            // Advance the model using the same inputs the DUT sees at the coming edge.
            if (m_act) begin
                if (!live) m_act = 1'b0;
                else if (ramstate == 2'd2) begin
                    m_act = 1'b0;
                    m_rr = (m_cpu + 1) % CPUS;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < CPUS; k++) begin
                    c = (m_rr + k) % CPUS;
                    if (!found && (iREN[c] || dREN[c] || dWEN[c])) begin
                        found = 1'b1; m_act = 1'b1; m_cpu = c;
                        m_kind  = dWEN[c] ? 2 : (dREN[c] ? 1 : 0);
                        m_addr  = (m_kind == 0) ? iaddr[c*WORD +: WORD] : daddr[c*WORD +: WORD];
                        m_store = dstore[c*WORD +: WORD];
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
